spi_blink_slave: RTL and testbench

- SPI responder (mode 0, CS active-low) clocked by the on-chip oscillator; serves the ESP32 host, which is the SPI initiator.
- Oversamples SCLK/MOSI/CS, decodes 2-byte register frames into a small register bank, and drives a blink LED from a programmable divider.
- Sits between the FPGA SPI pins and the LED pin in the spi-blink design.

---
 rtl/spi_blink_slave.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_blink_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_blink_slave.sv
// SPI mode-0 register responder plus programmable LED blinker, all in the sys_clk domain.
// Optional macro SPI_BLINK_ERRCNT_EN adds a saturating aborted-frame counter (ERRCNT, 0x03).
module spi_blink_slave #(
    parameter logic [7:0]  ID_VALUE  = 8'hA5,
    parameter int unsigned DIV_SHIFT = 16
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic spi_sclk_i,
    input  logic spi_cs_n_i,
    input  logic spi_mosi_i,
    output logic spi_miso_o,
    output logic led_o,
    output logic frame_done_o
);

    // state | meaning
    // IDLE  | waiting for cs_n to fall; MISO held low
    // CMD   | shifting in R/nW + 7-bit address
    // DATA  | shifting data in (write) and register value out (read)
    // DONE  | frame complete; SCLK ignored until cs_n rises
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [2:0]  sclk_q;
    logic [2:0]  cs_n_q;
    logic [1:0]  mosi_q;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_fall;
    logic        cs_rise;
    logic        mosi_s;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic        rnw_q, rnw_d;
    logic [6:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic        frame_done_q, frame_done_d;
    logic        reg_wr;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_data;

    logic [1:0]  ctrl_q;
    logic [7:0]  div_q;
    logic [7:0]  frames_q;
    logic        div_wr;

    logic [7:0]  div_eff;
    logic [23:0] half_period;
    logic [23:0] term_cnt;
    logic [23:0] blink_cnt_q;
    logic        phase_q;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            sclk_q <= 3'b000;
            cs_n_q <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk_i};
            cs_n_q <= {cs_n_q[1:0], spi_cs_n_i};
            mosi_q <= {mosi_q[0], spi_mosi_i};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_n_q[1] & cs_n_q[2];
    assign cs_rise   = cs_n_q[1] & ~cs_n_q[2];
    assign mosi_s    = mosi_q[1];
    assign rx_byte   = {shift_in_q, mosi_s};

`ifdef SPI_BLINK_ERRCNT_EN
    logic [7:0] errcnt_q;
    logic       err_inc;

    assign err_inc = cs_rise && ((state_q == ST_CMD) || (state_q == ST_DATA))
                     && (bit_cnt_q != 3'd0);

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            errcnt_q <= 8'h00;
        end else if (err_inc && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end
`endif

    // Read data is looked up from the address bits as they complete, so it is ready at the CMD->DATA edge.
    always_comb begin
        rd_data = 8'h00;
        case (rx_byte[6:0])
            7'h00:   rd_data = {6'b000000, ctrl_q};
            7'h01:   rd_data = div_q;
            7'h02:   rd_data = frames_q;
`ifdef SPI_BLINK_ERRCNT_EN
            7'h03:   rd_data = errcnt_q;
`endif
            7'h7F:   rd_data = ID_VALUE;
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        rnw_d        = rnw_q;
        addr_d       = addr_q;
        miso_d       = miso_q;
        frame_done_d = 1'b0;
        reg_wr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = 3'd0;
                if (cs_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    shift_in_d = rx_byte[6:0];
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rnw_d       = rx_byte[7];
                        addr_d      = rx_byte[6:0];
                        shift_out_d = rx_byte[7] ? rd_data : 8'h00;
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sclk_fall) begin
                        miso_d      = shift_out_q[7];
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_in_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            reg_wr       = ~rnw_q;
                            frame_done_d = 1'b1;
                            state_d      = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_in_q   <= 7'd0;
            shift_out_q  <= 8'h00;
            rnw_q        <= 1'b0;
            addr_q       <= 7'd0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            rnw_q        <= rnw_d;
            addr_q       <= addr_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign div_wr = reg_wr && (addr_q == 7'h01);

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ctrl_q   <= 2'b00;
            div_q    <= 8'h10;
            frames_q <= 8'h00;
        end else begin
            if (reg_wr && (addr_q == 7'h00)) begin
                ctrl_q <= rx_byte[1:0];
            end
            if (div_wr) begin
                div_q <= rx_byte;
            end
            if (frame_done_d) begin
                frames_q <= frames_q + 8'd1;
            end
        end
    end

    // DIV of zero is treated as one so the blink period never collapses.
    assign div_eff     = (div_q == 8'h00) ? 8'h01 : div_q;
    assign half_period = 24'(div_eff) << DIV_SHIFT;
    assign term_cnt    = half_period - 24'd1;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            blink_cnt_q <= 24'd0;
            phase_q     <= 1'b0;
        end else if (!ctrl_q[0]) begin
            blink_cnt_q <= 24'd0;
            phase_q     <= 1'b0;
        end else if (div_wr) begin
            blink_cnt_q <= 24'd0;
        end else if (blink_cnt_q == term_cnt) begin
            blink_cnt_q <= 24'd0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 24'd1;
        end
    end

    assign spi_miso_o   = miso_q;
    assign frame_done_o = frame_done_q;
    assign led_o        = (phase_q & ctrl_q[0]) ^ ctrl_q[1];

endmodule

// File: tb/tb_spi_blink_slave.sv
// Directed bench for spi_blink_slave: table of register frames plus blink, abort, reset and wrap sequences.
module tb_spi_blink_slave;

    localparam int HALF = 40;

    logic clk;
    logic rst;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic led;
    logic frame_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   fd_count = 0;
    int   fd_cyc   = 0;
    int   last_rise_cyc = 0;
    int   exp_frames = 0;
    int   tq[$];
    logic led_prev = 1'b0;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[16];

    spi_blink_slave #(
        .ID_VALUE (8'hA5),
        .DIV_SHIFT(4)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .spi_sclk_i  (sclk),
        .spi_cs_n_i  (cs_n),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .led_o       (led),
        .frame_done_o(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (led !== led_prev) tq.push_back(cyc);
        led_prev = led;
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                            input bit rst_mid, output logic [7:0] rx);
        logic [15:0] word;
        word = {cmd, dat};
        rx = 8'h00;
        @(posedge clk);
        #2;
        cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[15-i];
            #(HALF);
            sclk = 1'b1;
            if (i >= 8) rx[15-i] = miso;
            if (i == 15) last_rise_cyc = cyc;
            #(HALF);
            sclk = 1'b0;
        end
        if (rst_mid) begin
            rst = 1'b1;
            #(HALF);
        end
        #(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        #(3*HALF);
        if (rst_mid) begin
            rst = 1'b0;
            #(2*HALF);
        end
        if (nbits == 16 && !rst_mid) exp_frames++;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, output logic [7:0] rx);
        spi_xfer(cmd, dat, 16, 1'b0, rx);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        int fd_before;
        int first_after;
        int n_wrap;

        vecs[0]  = '{8'hFF, 8'h00, 8'hA5};
        vecs[1]  = '{8'h82, 8'h00, 8'h01};
        vecs[2]  = '{8'h82, 8'h00, 8'h02};
        vecs[3]  = '{8'h80, 8'h00, 8'h00};
        vecs[4]  = '{8'h81, 8'h00, 8'h10};
        vecs[5]  = '{8'h00, 8'hFF, 8'h00};
        vecs[6]  = '{8'h80, 8'h00, 8'h03};
        vecs[7]  = '{8'h00, 8'h00, 8'h00};
        vecs[8]  = '{8'h02, 8'h55, 8'h00};
        vecs[9]  = '{8'h82, 8'h00, 8'h09};
        vecs[10] = '{8'h7F, 8'h00, 8'h00};
        vecs[11] = '{8'hFF, 8'h00, 8'hA5};
        vecs[12] = '{8'h85, 8'h00, 8'h00};
        vecs[13] = '{8'h01, 8'h01, 8'h00};
        vecs[14] = '{8'h81, 8'h00, 8'h01};
        vecs[15] = '{8'h83, 8'h00, 8'h00};

        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        #23;
        check("rst_miso", miso, 0);
        check("rst_led", led, 0);
        check("rst_frame_done", frame_done, 0);
        wait_cycles(3);
        #2;
        rst = 1'b0;
        wait_cycles(5);

        for (int i = 0; i < 16; i++) begin
            fd_before = fd_count;
            frame(vecs[i].cmd, vecs[i].dat, rx);
            check($sformatf("row%0d_rx", i), rx, vecs[i].exp_rx);
            check($sformatf("row%0d_fd", i), fd_count - fd_before, 1);
        end

        // blink at DIV=1: half-period 16
        frame(8'h00, 8'h01, rx);
        tq.delete();
        wait_cycles(70);
        check("blink16_count_ok", (tq.size() >= 3) ? 1 : 0, 1);
        if (tq.size() >= 3) begin
            check("blink16_gap0", tq[1] - tq[0], 16);
            check("blink16_gap1", tq[2] - tq[1], 16);
        end

        // DIV write restarts the counter; also frame_done latency
        tq.delete();
        frame(8'h01, 8'h02, rx);
        check("fd_latency", fd_cyc - last_rise_cyc, 3);
        wait_cycles(60);
        first_after = -1;
        foreach (tq[k]) if (first_after < 0 && tq[k] > fd_cyc) first_after = tq[k];
        check("div_restart", first_after - fd_cyc, 32);

        frame(8'h00, 8'h03, rx);
        tq.delete();
        wait_cycles(110);
        check("blink32_count_ok", (tq.size() >= 2) ? 1 : 0, 1);
        if (tq.size() >= 2) check("blink32_gap", tq[1] - tq[0], 32);

        frame(8'h00, 8'h02, rx);
        wait_cycles(5);
        tq.delete();
        wait_cycles(70);
        check("invert_static_led", led, 1);
        check("invert_static_toggles", tq.size(), 0);

        frame(8'h00, 8'h00, rx);
        wait_cycles(5);
        tq.delete();
        wait_cycles(70);
        check("off_led", led, 0);
        check("off_toggles", tq.size(), 0);

        // aborted write to CTRL after 5 data bits
        fd_before = fd_count;
        spi_xfer(8'h00, 8'hFF, 13, 1'b0, rx);
        check("abort_fd", fd_count - fd_before, 0);
        frame(8'h80, 8'h00, rx);
        check("abort_ctrl", rx, 8'h00);
        frame(8'h83, 8'h00, rx);
`ifdef SPI_BLINK_ERRCNT_EN
        check("abort_errcnt", rx, 8'h01);
`else
        check("abort_errcnt", rx, 8'h00);
`endif
        frame(8'h82, 8'h00, rx);
        check("abort_frames", rx, 8'((exp_frames - 1) % 256));

        // reset during DATA phase of a DIV write
        frame(8'h00, 8'h03, rx);
        fd_before = fd_count;
        spi_xfer(8'h01, 8'h20, 12, 1'b1, rx);
        exp_frames = 0;
        check("rst_mid_fd", fd_count - fd_before, 0);
        check("rst_mid_led", led, 0);
        frame(8'h81, 8'h00, rx);
        check("rst_mid_div", rx, 8'h10);
        frame(8'h80, 8'h00, rx);
        check("rst_mid_ctrl", rx, 8'h00);
        frame(8'h82, 8'h00, rx);
        check("rst_mid_frames", rx, 8'h02);
        frame(8'hFF, 8'h00, rx);
        check("rst_mid_id", rx, 8'hA5);

        // FRAMES wrap
        n_wrap = (256 - (exp_frames % 256)) % 256;
        fd_before = fd_count;
        for (int i = 0; i < n_wrap; i++) frame(8'h7F, 8'h00, rx);
        check("wrap_fd_count", fd_count - fd_before, n_wrap);
        frame(8'h82, 8'h00, rx);
        check("wrap_frames0", rx, 8'h00);
        frame(8'h82, 8'h00, rx);
        check("wrap_frames1", rx, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
